// File: rtl/rf_multiport.sv
`timescale 1ns/1ps
// rf_multiport
// Register file for the ID stage: DEPTH = 2**AW registers of DW bits, two
// write ports (port 2 wins on address collision), three combinational read
// ports with optional same-cycle write-to-read bypass, and a per-register
// pending scoreboard used by the hazard unit to stall on in-flight results.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   RFWr1/WA1/WD1        write port 1 (enable, address, data)
//   RFWr2/WA2/WD2        write port 2 (enable, address, data)
//   RA1..RA3 / RD1..RD3  read addresses / combinational read data
//   IssueEn/IA           mark register IA pending at the next edge
//   Busy1..Busy3         read operand pending and not bypassed this cycle
module rf_multiport #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          RFWr1,
  input  logic [AW-1:0] WA1,
  input  logic [DW-1:0] WD1,
  input  logic          RFWr2,
  input  logic [AW-1:0] WA2,
  input  logic [DW-1:0] WD2,
  input  logic [AW-1:0] RA1,
  input  logic [AW-1:0] RA2,
  input  logic [AW-1:0] RA3,
  output logic [DW-1:0] RD1,
  output logic [DW-1:0] RD2,
  output logic [DW-1:0] RD3,
  input  logic          IssueEn,
  input  logic [AW-1:0] IA,
  output logic          Busy1,
  output logic          Busy2,
  output logic          Busy3
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    r_mem [DEPTH];
  logic [DEPTH-1:0] r_pend;
  logic [DEPTH-1:0] w_pend_nxt;

  // Effective enables: writes/issues to a hardwired-zero register vanish.
  logic w_we1, w_we2, w_iss;
  assign w_we1 = RFWr1   && !((ZERO_REG != 0) && (WA1 == '0));
  assign w_we2 = RFWr2   && !((ZERO_REG != 0) && (WA2 == '0));
  assign w_iss = IssueEn && !((ZERO_REG != 0) && (IA  == '0));

  // Clears from retiring writes first, then the issue set, so a new
  // producer issued in the same cycle as a writeback keeps the bit set.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_we1) w_pend_nxt[WA1] = 1'b0;
    if (w_we2) w_pend_nxt[WA2] = 1'b0;
    if (w_iss) w_pend_nxt[IA]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_pend <= '0;
    end else begin
      if (w_we1 && !(w_we2 && (WA2 == WA1))) r_mem[WA1] <= WD1;
      if (w_we2) r_mem[WA2] <= WD2;
      r_pend <= w_pend_nxt;
    end
  end

  logic [AW-1:0] w_ra   [3];
  logic [DW-1:0] w_rd   [3];
  logic          w_busy [3];

  assign w_ra[0] = RA1;
  assign w_ra[1] = RA2;
  assign w_ra[2] = RA3;

  for (genvar g = 0; g < 3; g++) begin : g_rd
    logic w_zero, w_hit1, w_hit2;
    assign w_zero = (ZERO_REG != 0) && (w_ra[g] == '0);
    assign w_hit1 = (BYPASS != 0) && w_we1 && (WA1 == w_ra[g]);
    assign w_hit2 = (BYPASS != 0) && w_we2 && (WA2 == w_ra[g]);

    always_comb begin
      w_rd[g]   = r_mem[w_ra[g]];
      w_busy[g] = r_pend[w_ra[g]] && !(w_hit1 || w_hit2);
      if (w_zero) begin
        w_rd[g]   = '0;
        w_busy[g] = 1'b0;
      end else if (w_hit2) begin
        w_rd[g] = WD2;
      end else if (w_hit1) begin
        w_rd[g] = WD1;
      end
    end
  end

  assign RD1   = w_rd[0];
  assign RD2   = w_rd[1];
  assign RD3   = w_rd[2];
  assign Busy1 = w_busy[0];
  assign Busy2 = w_busy[1];
  assign Busy3 = w_busy[2];

endmodule

// File: tb/tb_rf_multiport.sv
`timescale 1ns/1ps
module tb_rf_multiport;

  logic        clk = 1'b0;
  logic        rst;
  logic        RFWr1, RFWr2, IssueEn;
  logic [4:0]  WA1, WA2, RA1, RA2, RA3, IA;
  logic [31:0] WD1, WD2;
  logic [31:0] RD1, RD2, RD3, nRD1, nRD2, nRD3;
  logic        Busy1, Busy2, Busy3, nBusy1, nBusy2, nBusy3;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_mem [32];
  logic [31:0] m_pend;

  always #5 clk = ~clk;

  rf_multiport #(.DW(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .RFWr1(RFWr1), .WA1(WA1), .WD1(WD1),
    .RFWr2(RFWr2), .WA2(WA2), .WD2(WD2),
    .RA1(RA1), .RA2(RA2), .RA3(RA3),
    .RD1(RD1), .RD2(RD2), .RD3(RD3),
    .IssueEn(IssueEn), .IA(IA),
    .Busy1(Busy1), .Busy2(Busy2), .Busy3(Busy3)
  );

  rf_multiport #(.DW(32), .AW(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst),
    .RFWr1(RFWr1), .WA1(WA1), .WD1(WD1),
    .RFWr2(RFWr2), .WA2(WA2), .WD2(WD2),
    .RA1(RA1), .RA2(RA2), .RA3(RA3),
    .RD1(nRD1), .RD2(nRD2), .RD3(nRD3),
    .IssueEn(IssueEn), .IA(IA),
    .Busy1(nBusy1), .Busy2(nBusy2), .Busy3(nBusy3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    RFWr1 = 0; RFWr2 = 0; IssueEn = 0;
    WA1 = 0; WA2 = 0; WD1 = 0; WD2 = 0; IA = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit byp);
    if (ra == 0) return 32'h0;
    if (byp && RFWr2 && WA2 == ra) return WD2;
    if (byp && RFWr1 && WA1 == ra) return WD1;
    return m_mem[ra];
  endfunction

  function automatic logic exp_busy(input logic [4:0] ra, input bit byp);
    if (ra == 0) return 1'b0;
    return m_pend[ra] && !(byp && ((RFWr1 && WA1 == ra) || (RFWr2 && WA2 == ra)));
  endfunction

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 0;
      m_pend = 0;
    end else begin
      logic [31:0] pn;
      pn = m_pend;
      if (RFWr1 && WA1 != 0) begin m_mem[WA1] = WD1; pn[WA1] = 0; end
      if (RFWr2 && WA2 != 0) begin m_mem[WA2] = WD2; pn[WA2] = 0; end
      if (IssueEn && IA != 0) pn[IA] = 1;
      m_pend = pn;
    end
  endtask

  initial begin
    idle();
    RA1 = 0; RA2 = 0; RA3 = 0;
    rst = 1;
    tick(); tick();
    rst = 0;

    // reset state
    RA1 = 5; #1;
    chk("rst_rd", RD1, 0);
    chk("rst_busy", {31'b0, Busy1}, 0);

    // preload mem[5]=0x1234 with pend[5] set
    RFWr1 = 1; WA1 = 5; WD1 = 32'h1234; IssueEn = 1; IA = 5;
    tick(); idle(); #1;
    chk("pre_rd", RD1, 32'h1234);
    chk("pre_busy", {31'b0, Busy1}, 1);

    // reset held for two edges with a write to reg 7 in flight
    rst = 1; RFWr1 = 1; WA1 = 7; WD1 = 32'h55;
    tick(); tick();
    rst = 0; idle(); RA1 = 5; RA2 = 7; #1;
    chk("rst2_rd5", RD1, 0);
    chk("rst2_busy5", {31'b0, Busy1}, 0);
    chk("rst2_rd7", RD2, 0);

    // zero register
    RFWr1 = 1; WA1 = 0; WD1 = 32'hDEADBEEF; IssueEn = 1; IA = 0; RA1 = 0; #1;
    chk("z_rd_wc", RD1, 0);
    chk("z_busy_wc", {31'b0, Busy1}, 0);
    tick(); idle(); #1;
    chk("z_rd_nx", RD1, 0);
    chk("z_busy_nx", {31'b0, Busy1}, 0);

    // collision on reg 9
    RFWr1 = 1; RFWr2 = 1; WA1 = 9; WA2 = 9; WD1 = 32'h11; WD2 = 32'h22; RA1 = 9; #1;
    chk("col_byp", RD1, 32'h22);
    chk("col_nb_wc", nRD1, 0);
    tick(); idle(); #1;
    chk("col_mem", RD1, 32'h22);
    chk("col_nb_mem", nRD1, 32'h22);

    // two writes to different addresses both land
    RFWr1 = 1; WA1 = 10; WD1 = 32'hAA; RFWr2 = 1; WA2 = 11; WD2 = 32'hBB;
    tick(); idle(); RA1 = 10; RA2 = 11; #1;
    chk("dual_p1", RD1, 32'hAA);
    chk("dual_p2", RD2, 32'hBB);

    // bypass on all three ports
    RFWr1 = 1; WA1 = 3; WD1 = 32'hA;
    tick(); idle();
    RFWr1 = 1; WA1 = 3; WD1 = 32'hB; RA1 = 3; RA2 = 3; RA3 = 3; #1;
    chk("byp_rd1", RD1, 32'hB);
    chk("byp_rd2", RD2, 32'hB);
    chk("byp_rd3", RD3, 32'hB);
    chk("nb_rd1_wc", nRD1, 32'hA);
    chk("nb_rd3_wc", nRD3, 32'hA);
    tick(); idle(); #1;
    chk("nb_rd1_nx", nRD1, 32'hB);

    // scoreboard
    IssueEn = 1; IA = 4; RA1 = 4; RA2 = 4; #1;
    chk("sb_issue_wc", {31'b0, Busy1}, 0);
    tick(); idle(); #1;
    chk("sb_set", {31'b0, Busy1}, 1);
    chk("sb_set_nb", {31'b0, nBusy2}, 1);
    RFWr2 = 1; WA2 = 4; WD2 = 32'h44; #1;
    chk("sb_wb_byp", {31'b0, Busy1}, 0);
    chk("sb_wb_nb", {31'b0, nBusy1}, 1);
    tick(); idle(); #1;
    chk("sb_clr", {31'b0, Busy1}, 0);
    chk("sb_clr_nb", {31'b0, nBusy1}, 0);
    chk("sb_wb_data", RD2, 32'h44);
    IssueEn = 1; IA = 4; RFWr1 = 1; WA1 = 4; WD1 = 32'h55; #1;
    tick(); idle(); #1;
    chk("sb_set_wins", {31'b0, Busy1}, 1);
    chk("sb_set_wins_nb", {31'b0, nBusy1}, 1);
    chk("sb_set_data", RD1, 32'h55);

    // random against reference model; start from a known reset
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 32; i++) m_mem[i] = 0;
    m_pend = 0;
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 99) == 0);
      RFWr1   = $urandom_range(0, 1);
      RFWr2   = $urandom_range(0, 1);
      IssueEn = $urandom_range(0, 2) == 0;
      WA1 = 5'($urandom_range(0, 7));
      WA2 = 5'($urandom_range(0, 7));
      IA  = 5'($urandom_range(0, 7));
      RA1 = 5'($urandom_range(0, 7));
      RA2 = 5'($urandom_range(0, 7));
      RA3 = 5'($urandom_range(0, 31));
      WD1 = $urandom;
      WD2 = $urandom;
      #1;
      chk("rnd_rd1", RD1, exp_rd(RA1, 1));
      chk("rnd_rd2", RD2, exp_rd(RA2, 1));
      chk("rnd_rd3", RD3, exp_rd(RA3, 1));
      chk("rnd_busy1", {31'b0, Busy1}, {31'b0, exp_busy(RA1, 1)});
      chk("rnd_busy2", {31'b0, Busy2}, {31'b0, exp_busy(RA2, 1)});
      chk("rnd_nb_rd1", nRD1, exp_rd(RA1, 0));
      chk("rnd_nb_busy1", {31'b0, nBusy1}, {31'b0, exp_busy(RA1, 0)});
      model_edge();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
